// File: rtl/cpu_tx_hs.sv
// cpu_tx_hs: CPU-side FIFO feeding a 4-phase send/ack handshake towards the peripheral.
// Optional SEND timeout abort enabled by defining CPU_TX_TIMEOUT_EN.
module cpu_tx_hs #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_dados,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     cpu_send,
  input  logic                     cpu_ack,
  output logic [DATA_W-1:0]        cpu_dados,
  output logic                     tx_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be >= 2");
  end

  logic [1:0]             state_q, state_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [DATA_W-1:0]      mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   send_q, send_d;
  logic [DATA_W-1:0]      dados_q, dados_d;
  logic                   ack_s, push, pop, abort;

  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign full      = count_q == (PW+1)'(DEPTH);
  assign count     = count_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign cpu_send  = send_q;
  assign cpu_dados = dados_q;

  always_comb begin
    push     = wr_en && !full;
    // a held-high ack in IDLE blocks new sends until the peripheral releases it
    pop      = (state_q == IDLE) && (count_q != '0) && !ack_s;
    sync_d   = {sync_q[SYNC_STAGES-2:0], cpu_ack};
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_dados;
    state_d  = state_q;
    send_d   = send_q;
    dados_d  = pop ? mem_q[rd_ptr_q] : dados_q;
    if (pop) begin
      state_d = SEND;
      send_d  = 1'b1;
    end
    if (state_q == SEND && (ack_s || abort)) begin
      state_d = WAIT_LOW;
      send_d  = 1'b0;
    end
    if (state_q == WAIT_LOW && !ack_s) state_d = IDLE;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sync_q   <= '0;
      send_q   <= 1'b0;
      dados_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sync_q   <= sync_d;
      send_q   <= send_d;
      dados_q  <= dados_d;
    end
  end

`ifdef CPU_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // counter sits at zero outside SEND, so it is already clear on entry
  always_comb begin
    tmo_d = (state_q == SEND) ? tmo_q + 1'b1 : '0;
    abort = (state_q == SEND) && !ack_s && (tmo_q == TW'(TIMEOUT_CYC - 1));
    err_d = abort;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign tx_err = err_q;
`else
  assign abort  = 1'b0;
  assign tx_err = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_tx_hs.sv
// tb_cpu_tx_hs: randomized self-checking bench for cpu_tx_hs with a 4-phase peripheral model.
module tb_cpu_tx_hs;
  logic       cpu_clk = 1'b0;
  logic       cpu_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_dados = '0;
  logic       full, busy, cpu_send, tx_err;
  logic [2:0] count;
  logic       cpu_ack = 1'b0;
  logic [3:0] cpu_dados;

  int total = 0;
  int bad = 0;

  int  periph_mode = 0;
  logic ack_force = 1'b0;
  bit  rnd_lat = 0;
  int  lat_hi = 1;
  int  lat_lo = 1;
  int  hi_cnt = 0;
  int  lo_cnt = 0;
  logic [3:0] rx_q[$];

  cpu_tx_hs #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .wr_en(wr_en), .wr_dados(wr_dados),
    .full(full), .count(count), .busy(busy), .cpu_send(cpu_send),
    .cpu_ack(cpu_ack), .cpu_dados(cpu_dados), .tx_err(tx_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  // peripheral: mode 0 holds ack at ack_force, mode 1 acks after lat_hi and releases after lat_lo
  always @(negedge cpu_clk) begin
    if (periph_mode == 0) begin
      cpu_ack = ack_force;
      hi_cnt = 0;
      lo_cnt = 0;
    end else if (cpu_send && !cpu_ack) begin
      if (hi_cnt >= lat_hi) begin
        cpu_ack = 1'b1;
        rx_q.push_back(cpu_dados);
        hi_cnt = 0;
        if (rnd_lat) lat_hi = $urandom_range(0, 3);
      end else hi_cnt++;
    end else if (!cpu_send && cpu_ack) begin
      if (lo_cnt >= lat_lo) begin
        cpu_ack = 1'b0;
        lo_cnt = 0;
        if (rnd_lat) lat_lo = $urandom_range(0, 3);
      end else lo_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    periph_mode = 0;
    ack_force = 1'b0;
    wr_en = 1'b0;
    cpu_rst = 1'b0;
    tick();
    tick();
    cpu_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    periph_mode = 0;
    ack_force = 1'b0;
    cpu_rst = 1'b0;
    tick();
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (cpu_send !== 1'b0) begin bad++; $display("FAIL reset_send got=%0b exp=0", cpu_send); end
    total++; if (cpu_dados !== 4'h0) begin bad++; $display("FAIL reset_dados got=%h exp=0", cpu_dados); end
    total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_txerr got=%0b exp=0", tx_err); end
    cpu_rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t_ack = -1;
    int t_sf = -1;
    int t_al = -1;
    int t_idle = -1;
    int base = rx_q.size();
    lat_hi = 3;
    lat_lo = 1;
    rnd_lat = 0;
    periph_mode = 1;
    wr_en = 1'b1;
    wr_dados = 4'hA;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 3'd1 || cpu_send !== 1'b0) begin bad++; $display("FAIL basic_edgeN got count=%0d send=%0b exp count=1 send=0", count, cpu_send); end
    tick();
    total++; if (cpu_send !== 1'b1) begin bad++; $display("FAIL basic_send_rise got=%0b exp=1", cpu_send); end
    total++; if (cpu_dados !== 4'hA) begin bad++; $display("FAIL basic_dados got=%h exp=a", cpu_dados); end
    for (int i = 0; i < 60 && t_idle < 0; i++) begin
      tick();
      if (t_ack < 0 && cpu_ack) t_ack = i;
      if (t_ack >= 0 && t_sf < 0 && !cpu_send) t_sf = i;
      if (t_sf >= 0 && t_al < 0 && !cpu_ack) t_al = i;
      if (t_al >= 0 && t_idle < 0 && !busy) t_idle = i;
    end
    total++; if (t_ack < 0 || t_sf - t_ack != 2) begin bad++; $display("FAIL basic_send_fall_lat got=%0d exp=2 (ack at %0d)", t_sf - t_ack, t_ack); end
    total++; if (t_al < 0 || t_idle - t_al != 2) begin bad++; $display("FAIL basic_idle_lat got=%0d exp=2 (ack low at %0d)", t_idle - t_al, t_al); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%0b exp=0", busy); end
    total++; if (rx_q.size() != base + 1 || rx_q[base] !== 4'hA) begin bad++; $display("FAIL basic_rx got size=%0d exp size=%0d word a", rx_q.size(), base + 1); end
  endtask

  task automatic test_fill();
    int ec[5] = '{1, 1, 2, 3, 4};
    int base;
    do_reset();
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_dados = 4'(i + 1);
      tick();
      total++; if (count !== 3'(ec[i]) || full !== (ec[i] == 4)) begin bad++; $display("FAIL fill_w%0d got count=%0d full=%0b exp count=%0d", i + 1, count, full, ec[i]); end
    end
    wr_dados = 4'h6;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL fill_drop got count=%0d full=%0b exp count=4 full=1", count, full); end
    lat_hi = 1;
    lat_lo = 1;
    rnd_lat = 0;
    periph_mode = 1;
    for (int i = 0; i < 200 && busy; i++) tick();
    repeat (4) tick();
    total++; if (rx_q.size() != base + 5) begin bad++; $display("FAIL fill_rx_len got=%0d exp=%0d", rx_q.size() - base, 5); end
    for (int i = 0; i < 5 && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base + i] !== 4'(i + 1)) begin bad++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, rx_q[base + i], i + 1); end
    end
  endtask

  task automatic test_ack_held();
    bit quiet = 1;
    int base;
    do_reset();
    ack_force = 1'b1;
    repeat (4) tick();
    base = rx_q.size();
    wr_en = 1'b1;
    wr_dados = 4'h7;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_send) quiet = 0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL held_no_send got send=1 exp=0 while ack high"); end
    ack_force = 1'b0;
    tick();
    tick();
    total++; if (cpu_send !== 1'b0) begin bad++; $display("FAIL held_sync_wait got=%0b exp=0", cpu_send); end
    tick();
    total++; if (cpu_send !== 1'b1 || cpu_dados !== 4'h7) begin bad++; $display("FAIL held_release got send=%0b dados=%h exp send=1 dados=7", cpu_send, cpu_dados); end
    lat_hi = 1;
    lat_lo = 1;
    rnd_lat = 0;
    periph_mode = 1;
    for (int i = 0; i < 100 && busy; i++) tick();
    repeat (10) tick();
    total++; if (rx_q.size() != base + 1 || rx_q[base] !== 4'h7) begin bad++; $display("FAIL held_one_hs got count=%0d exp=1 word 7", rx_q.size() - base); end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    int base;
    do_reset();
    base = rx_q.size();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_dados = 4'(9 + i);
      tick();
    end
    wr_en = 1'b0;
    total++; if (cpu_send !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL rmid_pre got send=%0b count=%0d exp send=1 count=3", cpu_send, count); end
    #2;
    cpu_rst = 1'b0;
    #1;
    total++; if (cpu_send !== 1'b0) begin bad++; $display("FAIL rmid_send got=%0b exp=0", cpu_send); end
    total++; if (count !== 3'd0 || full !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_fifo got count=%0d full=%0b busy=%0b exp all 0", count, full, busy); end
    total++; if (cpu_dados !== 4'h0) begin bad++; $display("FAIL rmid_dados got=%h exp=0", cpu_dados); end
    tick();
    cpu_rst = 1'b1;
    lat_hi = 1;
    lat_lo = 1;
    periph_mode = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_send) quiet = 0;
    end
    total++; if (!quiet || rx_q.size() != base) begin bad++; $display("FAIL rmid_stale got sends=%0d exp=0", rx_q.size() - base); end
  endtask

  task automatic test_stress();
    logic [3:0] exp_q[$];
    logic [1:0] ack_pipe = 2'b00;
    int   mcount = 0;
    int   base;
    logic pre_send, pre_acks;
    logic [3:0] pre_dados;
    bit   did_wr;
    do_reset();
    base = rx_q.size();
    rnd_lat = 1;
    lat_hi = $urandom_range(0, 3);
    lat_lo = $urandom_range(0, 3);
    periph_mode = 1;
    for (int c = 0; c < 300; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_dados = 4'($urandom);
      did_wr = wr_en && (mcount != 4);
      pre_send = cpu_send;
      pre_dados = cpu_dados;
      pre_acks = ack_pipe[1];
      tick();
      ack_pipe = {ack_pipe[0], cpu_ack};
      if (did_wr) begin
        exp_q.push_back(wr_dados);
        mcount++;
      end
      if (cpu_send && !pre_send) mcount--;
      total++; if (count !== 3'(mcount)) begin bad++; $display("FAIL stress_count c=%0d got=%0d exp=%0d", c, count, mcount); end
      total++; if (full !== (mcount == 4)) begin bad++; $display("FAIL stress_full c=%0d got=%0b exp=%0b", c, full, mcount == 4); end
      total++; if (cpu_dados !== pre_dados && (pre_send || pre_acks)) begin bad++; $display("FAIL stress_stable c=%0d got dados %h->%h while send=%0b ack_s=%0b", c, pre_dados, cpu_dados, pre_send, pre_acks); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 300 && busy; i++) tick();
    repeat (8) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stress_drain got busy=%0b exp=0", busy); end
    total++; if (rx_q.size() - base != exp_q.size()) begin bad++; $display("FAIL stress_rx_len got=%0d exp=%0d", rx_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++) begin
      total++; if (rx_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL stress_order idx=%0d got=%h exp=%h", i, rx_q[base + i], exp_q[i]); end
    end
    rnd_lat = 0;
  endtask

  task automatic test_timeout();
    int errs = 0;
    bit held = 1;
    do_reset();
    wr_en = 1'b1;
    wr_dados = 4'hB;
    tick();
    wr_dados = 4'hC;
    tick();
    wr_en = 1'b0;
    total++; if (cpu_send !== 1'b1 || cpu_dados !== 4'hB) begin bad++; $display("FAIL tmo_start got send=%0b dados=%h exp send=1 dados=b", cpu_send, cpu_dados); end
`ifdef CPU_TX_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (tx_err) errs++;
      if (k == 8) begin
        total++; if (tx_err !== 1'b1 || cpu_send !== 1'b0) begin bad++; $display("FAIL tmo_abort got err=%0b send=%0b exp err=1 send=0", tx_err, cpu_send); end
      end
      if (k == 10) begin
        total++; if (cpu_send !== 1'b1 || cpu_dados !== 4'hC) begin bad++; $display("FAIL tmo_next got send=%0b dados=%h exp send=1 dados=c", cpu_send, cpu_dados); end
      end
    end
    total++; if (errs != 1) begin bad++; $display("FAIL tmo_pulses got=%0d exp=1", errs); end
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (tx_err) errs++;
      if (cpu_send !== 1'b1 || cpu_dados !== 4'hB) held = 0;
    end
    total++; if (!held) begin bad++; $display("FAIL tmo_hold got send dropped exp send held with b"); end
    total++; if (errs != 0) begin bad++; $display("FAIL tmo_noerr got=%0d exp=0", errs); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_ack_held();
    test_reset_mid();
    test_stress();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
